// File: rtl/dmem_stack_ctrl_pkg.sv
// Shared encodings for the RNBIP-2 data-memory / stack sequencer.
package dmem_ctrl_pkg;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_PUSH  = 3'b010;
    localparam logic [2:0] OP_POP   = 3'b011;
    localparam logic [2:0] OP_CALL  = 3'b100;
    localparam logic [2:0] OP_RET   = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEC,
        ST_WRITE,
        ST_READ,
        ST_FAULT
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE,
        FC_OVERFLOW,
        FC_UNDERFLOW,
        FC_ILLEGAL
    } fault_cause_t;

    // Classifies a request against the current SP before any state changes.
    function automatic fault_cause_t fault_cause(input logic [2:0] op,
                                                 input logic [7:0] sp,
                                                 input logic [7:0] sp_init,
                                                 input logic [7:0] sp_limit);
        fault_cause_t fc;
        fc = FC_NONE;
        case (op)
            OP_PUSH, OP_CALL: if (sp == sp_limit) fc = FC_OVERFLOW;
            OP_POP, OP_RET:   if (sp == sp_init)  fc = FC_UNDERFLOW;
            OP_LOAD, OP_STORE: fc = FC_NONE;
            default:          fc = FC_ILLEGAL;
        endcase
        return fc;
    endfunction

endpackage

// File: rtl/dmem_stack_ctrl_if.sv
// Request handshake and memory-control bundle between decode and the stack sequencer.
interface dmem_stack_ctrl_if;
    logic       req_valid;
    logic [2:0] req_op;
    logic       req_ready;
    logic       sp_wr_en;
    logic [7:0] sp_wr_data;
    logic [7:0] sp_out;
    logic       wr;
    logic       s20;
    logic       s50;
    logic       load_rn;
    logic       load_pc;
    logic       done;
    logic       fault;
    logic       busy;

    modport master (
        output req_valid, req_op, sp_wr_en, sp_wr_data,
        input  req_ready, sp_out, wr, s20, s50, load_rn, load_pc, done, fault, busy
    );

    modport slave (
        input  req_valid, req_op, sp_wr_en, sp_wr_data,
        output req_ready, sp_out, wr, s20, s50, load_rn, load_pc, done, fault, busy
    );
endinterface

// File: rtl/dmem_stack_ctrl.sv
// Data-memory / stack-pointer sequencer: one LOAD/STORE/PUSH/POP/CALL/RET at a time,
// registered memory controls and load strobes.
module dmem_stack_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter logic [7:0] SP_INIT  = 8'h00,
    parameter logic [7:0] SP_LIMIT = 8'hC0
) (
    input logic              clk,
    input logic              reset,
    dmem_stack_ctrl_if.slave bus
);

    state_t     state;
    logic [2:0] op_q;
    logic [7:0] sp;
    logic       wr_q, s20_q, s50_q, load_rn_q, load_pc_q, done_q, fault_q, busy_q;

    assign bus.req_ready = (state == ST_IDLE) && !bus.sp_wr_en;
    assign bus.sp_out    = sp;
    assign bus.wr        = wr_q;
    assign bus.s20       = s20_q;
    assign bus.s50       = s50_q;
    assign bus.load_rn   = load_rn_q;
    assign bus.load_pc   = load_pc_q;
    assign bus.done      = done_q;
    assign bus.fault     = fault_q;
    assign bus.busy      = busy_q;

    // Outputs are set on the transition into a state so they are valid for
    // exactly the cycles spent in it; every cycle starts from all-strobes-low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            op_q      <= OP_LOAD;
            sp        <= SP_INIT;
            wr_q      <= 1'b0;
            s20_q     <= 1'b0;
            s50_q     <= 1'b0;
            load_rn_q <= 1'b0;
            load_pc_q <= 1'b0;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            wr_q      <= 1'b0;
            s20_q     <= 1'b0;
            s50_q     <= 1'b0;
            load_rn_q <= 1'b0;
            load_pc_q <= 1'b0;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    busy_q <= 1'b0;
                    if (bus.sp_wr_en) begin
                        sp <= bus.sp_wr_data;
                    end else if (bus.req_valid) begin
                        op_q   <= bus.req_op;
                        busy_q <= 1'b1;
                        if (fault_cause(bus.req_op, sp, SP_INIT, SP_LIMIT) != FC_NONE) begin
                            state   <= ST_FAULT;
                            done_q  <= 1'b1;
                            fault_q <= 1'b1;
                        end else begin
                            case (bus.req_op)
                                OP_PUSH, OP_CALL: state <= ST_DEC;
                                OP_STORE: begin
                                    state  <= ST_WRITE;
                                    wr_q   <= 1'b1;
                                    s50_q  <= 1'b1;
                                    done_q <= 1'b1;
                                end
                                OP_POP: begin
                                    state     <= ST_READ;
                                    s20_q     <= 1'b1;
                                    load_rn_q <= 1'b1;
                                    done_q    <= 1'b1;
                                end
                                OP_RET: begin
                                    state     <= ST_READ;
                                    s20_q     <= 1'b1;
                                    load_pc_q <= 1'b1;
                                    done_q    <= 1'b1;
                                end
                                OP_LOAD: begin
                                    state     <= ST_READ;
                                    load_rn_q <= 1'b1;
                                    done_q    <= 1'b1;
                                end
                                default: begin
                                    state   <= ST_FAULT;
                                    done_q  <= 1'b1;
                                    fault_q <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                ST_DEC: begin
                    sp     <= sp - 8'd1;
                    state  <= ST_WRITE;
                    wr_q   <= 1'b1;
                    s20_q  <= 1'b1;
                    s50_q  <= (op_q == OP_PUSH);
                    done_q <= 1'b1;
                end
                ST_READ: begin
                    // Memory has already been read at the pre-increment SP.
                    if (op_q == OP_POP || op_q == OP_RET) sp <= sp + 8'd1;
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_stack_ctrl.sv
// Randomized self-checking bench for dmem_stack_ctrl with a transaction-level model.
module tb_dmem_stack_ctrl;

    localparam logic [7:0] SP_INIT  = 8'h00;
    localparam logic [7:0] SP_LIMIT = 8'hC0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_stack_ctrl_if bus ();

    dmem_stack_ctrl #(.SP_INIT(SP_INIT), .SP_LIMIT(SP_LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Environment: the memory reacting to the DUT's controls, plus RN/NPC/R0 sources.
    logic [7:0] tb_mem  [256];
    logic [7:0] ref_mem [256];
    logic [7:0] rn, npc, r0;
    logic [7:0] msp;

    wire [7:0] mem_addr = bus.s20 ? bus.sp_out : r0;
    wire [7:0] mem_din  = bus.s50 ? rn : npc;

    always @(posedge clk) if (bus.wr) tb_mem[mem_addr] <= mem_din;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sig();
        return {bus.busy, bus.done, bus.fault, bus.wr, bus.s20, bus.s50, bus.load_rn, bus.load_pc};
    endfunction

    // Issue one request (optionally colliding with a direct SP load) and check every cycle.
    task automatic do_op(input logic [2:0] op, input bit with_load, input logic [7:0] load_val);
        logic [7:0] exp_sig [2];
        logic [7:0] exp_sp  [2];
        int unsigned ncyc;
        bit is_fault, is_read;
        logic [7:0] rd_addr;
        rn  = 8'($urandom);
        npc = 8'($urandom);
        r0  = 8'($urandom);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        if (with_load) begin
            bus.sp_wr_en   = 1'b1;
            bus.sp_wr_data = load_val;
            #1 check("ready_during_spload", bus.req_ready, 1'b0);
            @(posedge clk); #1;
            bus.sp_wr_en = 1'b0;
            msp = load_val;
            check("sp_after_load", bus.sp_out, msp);
            check("idle_after_load", sig(), 8'h00);
        end
        #1 check("ready", bus.req_ready, 1'b1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;

        is_fault = (op > 3'd5) ||
                   ((op == 3'd2 || op == 3'd4) && msp == SP_LIMIT) ||
                   ((op == 3'd3 || op == 3'd5) && msp == SP_INIT);
        is_read = 1'b0;
        rd_addr = 8'h00;
        ncyc = 1;
        exp_sp[0] = msp;
        exp_sp[1] = msp;
        if (is_fault) begin
            exp_sig[0] = 8'b1110_0000;
        end else begin
            case (op)
                3'd0: begin exp_sig[0] = 8'b1100_0010; is_read = 1'b1; rd_addr = r0; end
                3'd1: begin exp_sig[0] = 8'b1101_0100; ref_mem[r0] = rn; end
                3'd3: begin exp_sig[0] = 8'b1100_1010; is_read = 1'b1; rd_addr = msp; msp = msp + 8'd1; end
                3'd5: begin exp_sig[0] = 8'b1100_1001; is_read = 1'b1; rd_addr = msp; msp = msp + 8'd1; end
                default: begin
                    ncyc = 2;
                    exp_sig[0] = 8'b1000_0000;
                    exp_sig[1] = (op == 3'd2) ? 8'b1101_1100 : 8'b1101_1000;
                    msp = msp - 8'd1;
                    exp_sp[1] = msp;
                    ref_mem[msp] = (op == 3'd2) ? rn : npc;
                end
            endcase
        end

        for (int unsigned c = 0; c < ncyc; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            check($sformatf("op%0d_cyc%0d_sig", op, c), sig(), exp_sig[c]);
            check($sformatf("op%0d_cyc%0d_sp", op, c), bus.sp_out, exp_sp[c]);
            if (is_read) check($sformatf("op%0d_rdata", op), tb_mem[mem_addr], ref_mem[rd_addr]);
        end
        @(posedge clk); #1;
        check($sformatf("op%0d_idle_sig", op), sig(), 8'h00);
        check($sformatf("op%0d_idle_sp", op), bus.sp_out, msp);
    endtask

    initial begin
        logic [7:0] lv;
        logic [2:0] rop;
        for (int i = 0; i < 256; i++) begin
            tb_mem[i]  = 8'($urandom);
            ref_mem[i] = tb_mem[i];
        end
        rn = '0; npc = '0; r0 = '0;
        bus.req_valid = 1'b0; bus.req_op = '0;
        bus.sp_wr_en = 1'b0;  bus.sp_wr_data = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_sig", sig(), 8'h00);
        check("reset_sp", bus.sp_out, SP_INIT);
        reset = 1'b0;
        msp = SP_INIT;
        @(posedge clk); #1;
        check("reset_ready", bus.req_ready, 1'b1);

        do_op(3'd2, 1'b0, 8'h00);      // PUSH -> writes 0xFF
        do_op(3'd4, 1'b0, 8'h00);      // CALL -> writes 0xFE with NPC
        do_op(3'd5, 1'b0, 8'h00);      // RET reads back NPC from 0xFE
        do_op(3'd3, 1'b0, 8'h00);      // POP -> sp back to 0x00
        do_op(3'd3, 1'b0, 8'h00);      // underflow
        do_op(3'd2, 1'b1, SP_LIMIT);   // overflow after collided direct load
        do_op(3'd1, 1'b0, 8'h00);      // STORE
        do_op(3'd0, 1'b0, 8'h00);      // LOAD
        do_op(3'd7, 1'b0, 8'h00);      // illegal
        do_op(3'd6, 1'b0, 8'h00);

        // Reset while a PUSH sits in its decrement cycle.
        bus.sp_wr_en = 1'b1; bus.sp_wr_data = 8'h40;
        @(posedge clk); #1;
        bus.sp_wr_en = 1'b0;
        bus.req_valid = 1'b1; bus.req_op = 3'd2;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("dec_before_reset", sig(), 8'b1000_0000);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_sig", sig(), 8'h00);
        check("abort_sp", bus.sp_out, SP_INIT);
        msp = SP_INIT;
        @(posedge clk); #1;
        check("abort_no_wr", sig(), 8'h00);

        for (int n = 0; n < 400; n++) begin
            rop = 3'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 4))
                    0: lv = SP_INIT;
                    1: lv = SP_LIMIT;
                    2: lv = SP_LIMIT + 8'd1;
                    3: lv = 8'hFF;
                    default: lv = 8'($urandom);
                endcase
                do_op(rop, 1'b1, lv);
            end else begin
                do_op(rop, 1'b0, 8'h00);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_stack_ctrl.md
Name: dmem_stack_ctrl

Overview:
Sequencer for the 256x8 data memory and stack pointer of the RNBIP-2 core. It accepts one memory operation at a time from the decode/control unit: LOAD, STORE, PUSH, POP, CALL or RET. It owns the SP register and drives the memory's WR, S20 (address select, 1=SP, 0=R0) and S50 (write-data select, 1=RN, 0=NPC) controls. It also raises load strobes so the register file or PC captures the memory read data.

Parameters:
SP_INIT, 8'h00, SP value after reset (empty full-descending stack; first push writes 8'hFF)
SP_LIMIT, 8'hC0, lowest legal stack address; a PUSH/CALL with sp==SP_LIMIT is an overflow

Ports:
clk  in  1  system clock, all state changes on rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  operation request
req_op  in  3  000 LOAD, 001 STORE, 010 PUSH, 011 POP, 100 CALL, 101 RET, 110/111 illegal
req_ready  out  1  controller can accept a request this cycle
sp_wr_en  in  1  direct SP load (LDSP instruction)
sp_wr_data  in  8  value for direct SP load
sp_out  out  8  current SP, drives memory SP_in
wr  out  1  memory write enable
s20  out  1  address mux select
s50  out  1  write-data mux select
load_rn  out  1  one-cycle strobe: RN captures memory dataOut
load_pc  out  1  one-cycle strobe: PC captures memory dataOut
done  out  1  one-cycle pulse: operation complete (with or without fault)
fault  out  1  one-cycle pulse with done: overflow, underflow or illegal op
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state=IDLE, sp=SP_INIT; wr, s20, s50, load_rn, load_pc, done, fault, busy all 0. Reset mid-operation aborts it. No write occurs in the reset cycle.
- States: IDLE, DEC, WRITE, READ, FAULT.
- req_ready = (state==IDLE) && !sp_wr_en. A request is accepted when req_valid && req_ready. req_op is latched on acceptance.
- sp_wr_en in IDLE: sp<=sp_wr_data; a simultaneous request is not accepted. sp_wr_en outside IDLE is ignored.
- In IDLE, all strobes and selects are 0.
- Fault check at acceptance:
  - PUSH/CALL with sp==SP_LIMIT is overflow.
  - POP/RET with sp==SP_INIT is underflow.
  - Illegal op is a fault.
  - Any fault -> FAULT state. No memory write, sp unchanged.
- PUSH/CALL: IDLE -> DEC (sp<=sp-1) -> WRITE -> IDLE.
  - In WRITE: wr=1, s20=1, done=1; s50=1 for PUSH, 0 for CALL.
  - Write lands at the decremented SP. done occurs 2 cycles after acceptance.
- STORE: IDLE -> WRITE with wr=1, s20=0, s50=1, done=1. Latency 1.
- POP/RET: IDLE -> READ with s20=1, done=1, and sp<=sp+1 at the end of READ. load_rn=1 for POP, load_pc=1 for RET. Memory reads combinationally at the pre-increment SP. Latency 1.
- LOAD: IDLE -> READ with s20=0, load_rn=1, done=1.
- FAULT: done=1, fault=1, all other strobes 0 -> IDLE.
- SP arithmetic is 8-bit modulo, but the fault checks prevent wrap past SP_INIT or SP_LIMIT through stack ops. Direct SP load is unchecked.
- The WRITE and READ states always return to IDLE. Back-to-back ops: a new request can be accepted the cycle after done.

Decomposition:
- Package dmem_ctrl_pkg holds:
  - op encoding localparams OP_LOAD..OP_RET
  - state encoding
  - fault-cause constants, for a future status register
- Single module. No sub-module is natural; the SP register stays inline.

Test Plan:
- Reset, then PUSH with RN selected -> DEC cycle; next cycle wr=1, s20=1, s50=1, sp_out=8'hFF, done=1; req_ready again the following cycle.
- CALL then RET from sp=8'hFF -> CALL writes at 8'hFE with s50=0, sp=8'hFE. RET asserts load_pc=1 with s20=1 at address 8'hFE, then sp=8'hFF.
- POP at sp=SP_INIT=8'h00 -> next cycle done=1, fault=1, wr=0, load_rn=0, sp stays 8'h00.
- sp_wr_en with sp_wr_data=8'hC0, then PUSH -> overflow fault, no wr. Also: sp_wr_en in the same cycle as req_valid -> req_ready=0, SP loaded, request held and accepted the next cycle.
- STORE then LOAD -> STORE: wr=1, s20=0, s50=1, done one cycle after acceptance. LOAD: load_rn=1, s20=0, wr=0, sp unchanged.
- reset asserted during DEC of a PUSH -> following cycle IDLE, sp=SP_INIT, wr never asserted. Also: req_op=3'b111 -> fault pulse.
